// File: rtl/decode_pkg.sv
// Shared opcode constants, decoded-bundle type and pure decode helpers
// for the decode_queue block.
package decode_pkg;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // imm holds the 32-bit form; bit 31 is the sign for wider XLEN.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [25:0] addr;
    logic [31:0] imm;
    fmt_t        fmt;
    logic        illegal;
  } dec_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, [OP_J:OP_LUI], OP_LB, OP_LH,
                      OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic fmt_t fmt_of(input logic [5:0] op);
    if (op == OP_RTYPE) return FMT_R;
    if (op == OP_J || op == OP_JAL) return FMT_J;
    return FMT_I;
  endfunction

  function automatic logic [31:0] ext_imm(
    input logic [5:0]  op,
    input logic [15:0] imm16
  );
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
      return {16'h0000, imm16};
    if (op == OP_LUI)
      return {imm16, 16'h0000};
    return {{16{imm16[15]}}, imm16};
  endfunction

  function automatic dec_t decode(input logic [31:0] insn);
    dec_t d;
    d.opcode  = insn[31:26];
    d.rs      = insn[25:21];
    d.rt      = insn[20:16];
    d.rd      = insn[15:11];
    d.shamt   = insn[10:6];
    d.funct   = insn[5:0];
    d.addr    = insn[25:0];
    d.imm     = ext_imm(insn[31:26], insn[15:0]);
    d.fmt     = fmt_of(insn[31:26]);
    d.illegal = !is_legal(insn[31:26]);
    return d;
  endfunction

endpackage

// File: rtl/decode_queue_fifo.sv
// Instruction FIFO: storage, wrapping pointers and occupancy count,
// with a synchronous flush that overrides push and pop.
module insn_fifo
  import decode_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             not_full,
  output logic             not_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign not_full  = (count_q != CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign rd_data   = mem_q[rd_ptr_q];
  assign do_push   = push && not_full && !flush;
  assign do_pop    = pop && not_empty && !flush;

  // Pointers are AW bits wide, so DEPTH being a power of two wraps them.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/decode_queue.sv
// Queued MIPS decoder: FIFO in front of a registered decode stage.
// Define DECODE_STATS_EN to add dequeue and illegal-dequeue counters.
module decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [25:0]     out_addr,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_fmt,
  output logic            out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]     stat_insn_cnt,
  output logic [31:0]     stat_illegal_cnt
`endif
);

  logic [31:0] head;
  logic        head_valid;
  logic        load;
  logic        deq;
  logic        valid_q, valid_d;
  dec_t        dec_q, dec_d;

  insn_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (in_valid),
    .wr_data   (in_insn),
    .pop       (load),
    .rd_data   (head),
    .not_full  (in_ready),
    .not_empty (head_valid)
  );

  assign load = head_valid && (!valid_q || out_ready);
  assign deq  = valid_q && out_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    dec_d   = dec_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      dec_d   = decode(head);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_opcode  = dec_q.opcode;
  assign out_rs      = dec_q.rs;
  assign out_rt      = dec_q.rt;
  assign out_rd      = dec_q.rd;
  assign out_shamt   = dec_q.shamt;
  assign out_funct   = dec_q.funct;
  assign out_addr    = dec_q.addr;
  assign out_imm     = XLEN'($signed(dec_q.imm));
  assign out_fmt     = dec_q.fmt;
  assign out_illegal = dec_q.illegal;

`ifdef DECODE_STATS_EN
  logic [31:0] insn_cnt_q, insn_cnt_d;
  logic [31:0] ill_cnt_q, ill_cnt_d;

  // Flush is not a consume, and it never clears the counters.
  always_comb begin
    insn_cnt_d = insn_cnt_q;
    ill_cnt_d  = ill_cnt_q;
    if (deq) begin
      insn_cnt_d = insn_cnt_q + 32'd1;
      if (dec_q.illegal) ill_cnt_d = ill_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_cnt_q <= '0;
      ill_cnt_q  <= '0;
    end else begin
      insn_cnt_q <= insn_cnt_d;
      ill_cnt_q  <= ill_cnt_d;
    end
  end

  assign stat_insn_cnt    = insn_cnt_q;
  assign stat_illegal_cnt = ill_cnt_q;
`else
  logic unused_deq;
  assign unused_deq = deq;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed decode vectors,
// stall/backpressure, flush, async reset and a randomized model run.
module tb_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int BW    = XLEN + 61;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs, out_rt, out_rd, out_shamt;
  logic [5:0]      out_funct;
  logic [25:0]     out_addr;
  logic [XLEN-1:0] out_imm;
  logic [1:0]      out_fmt;
  logic            out_illegal;
`ifdef DECODE_STATS_EN
  logic [31:0]     stat_insn_cnt, stat_illegal_cnt;
`endif

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_insn     (in_insn),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_rs      (out_rs),
    .out_rt      (out_rt),
    .out_rd      (out_rd),
    .out_shamt   (out_shamt),
    .out_funct   (out_funct),
    .out_addr    (out_addr),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
`ifdef DECODE_STATS_EN
    ,
    .stat_insn_cnt    (stat_insn_cnt),
    .stat_illegal_cnt (stat_illegal_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: queue of accepted-but-not-presented words plus output slot.
  logic [31:0] pend[$];
  logic        m_ov;
  logic [31:0] m_ow;

  logic [BW-1:0] act_bus;
  assign act_bus = {out_opcode, out_rs, out_rt, out_rd, out_shamt,
                    out_funct, out_addr, out_imm, out_fmt, out_illegal};

  function automatic logic [1:0] ref_fmt(input logic [31:0] w);
    int op = int'(w[31:26]);
    if (op == 0) return 2'd0;
    if (op == 2 || op == 3) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic ref_ill(input logic [31:0] w);
    int op = int'(w[31:26]);
    if (op == 0 || (op >= 2 && op <= 15)) return 1'b0;
    if (op inside {32, 33, 35, 36, 37, 40, 41, 43}) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w);
    int op = int'(w[31:26]);
    longint v;
    if (op >= 12 && op <= 14) v = longint'(w[15:0]);
    else if (op == 15) v = longint'($signed({w[15:0], 16'h0000}));
    else v = longint'($signed(w[15:0]));
    return XLEN'(v);
  endfunction

  function automatic logic [BW-1:0] exp_bus(input logic [31:0] w);
    return {w[31:26], w[25:21], w[20:16], w[15:11], w[10:6], w[5:0],
            w[25:0], ref_imm(w), ref_fmt(w), ref_ill(w)};
  endfunction

  task automatic model_reset();
    pend.delete();
    m_ov = 1'b0;
    m_ow = '0;
  endtask

  // Advance one edge; model updates from inputs held since last negedge.
  task automatic step();
    bit push, load;
    @(posedge clk);
    if (flush) begin
      pend.delete();
      m_ov = 1'b0;
    end else begin
      push = in_valid && (pend.size() < DEPTH);
      load = (pend.size() > 0) && (!m_ov || out_ready);
      if (load) begin
        m_ow = pend.pop_front();
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (push) pend.push_back(in_insn);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_insn = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
    checks++;
    if (act_bus !== '0) begin
      failures++;
      $display("FAIL reset_fields got %h want 0", act_bus);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || act_bus !== '0) begin
      failures++;
      $display("FAIL post_reset got v=%b bus=%h want v=0 bus=0",
               out_valid, act_bus);
    end
  endtask

  task automatic test_directed();
    logic [31:0]     w_t  [8] = '{32'h00000003, 32'h0C000003, 32'hC0000003,
                                 32'h80000003, 32'h00011020, 32'h2001FFFF,
                                 32'h3401FFFF, 32'h3C011234};
    logic [5:0]      op_t [8] = '{6'h00, 6'h03, 6'h30, 6'h20,
                                 6'h00, 6'h08, 6'h0D, 6'h0F};
    logic [1:0]      fm_t [8] = '{2'd0, 2'd2, 2'd1, 2'd1,
                                 2'd0, 2'd1, 2'd1, 2'd1};
    logic            il_t [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    logic [XLEN-1:0] im_t [8] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h1020,
                                 32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_insn = w_t[i];
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL lat_early[%0d] got v=%b want 0", i, out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_opcode !== op_t[i] ||
          out_fmt !== fm_t[i] || out_illegal !== il_t[i] ||
          out_imm !== im_t[i]) begin
        failures++;
        $display("FAIL vec[%0d] got v=%b op=%h fmt=%0d ill=%b imm=%h want v=1 op=%h fmt=%0d ill=%b imm=%h",
                 i, out_valid, out_opcode, out_fmt, out_illegal, out_imm,
                 op_t[i], fm_t[i], il_t[i], im_t[i]);
      end
      checks++;
      if (act_bus !== exp_bus(w_t[i])) begin
        failures++;
        $display("FAIL vec_bus[%0d] got %h want %h",
                 i, act_bus, exp_bus(w_t[i]));
      end
      if (i == 4) begin
        checks++;
        if (out_rs !== 5'd0 || out_rt !== 5'd1 || out_rd !== 5'd2 ||
            out_funct !== 6'h20) begin
          failures++;
          $display("FAIL rtype_regs got rs=%0d rt=%0d rd=%0d f=%h want 0 1 2 20",
                   out_rs, out_rt, out_rd, out_funct);
        end
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] words[$];
    int idx;
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL stall_ready[%0d] got %b want 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_insn = $urandom;
      words.push_back(in_insn);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_full got in_ready=%b want 0", in_ready);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || act_bus !== exp_bus(words[0])) begin
        failures++;
        $display("FAIL stall_hold[%0d] got v=%b bus=%h want v=1 bus=%h",
                 c, out_valid, act_bus, exp_bus(words[0]));
      end
      step();
    end
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20 && idx <= DEPTH; c++) begin
      if (out_valid) begin
        checks++;
        if (act_bus !== exp_bus(words[idx])) begin
          failures++;
          $display("FAIL drain[%0d] got %h want %h",
                   idx, act_bus, exp_bus(words[idx]));
        end
        idx++;
      end
      step();
    end
    checks++;
    if (idx != DEPTH + 1) begin
      failures++;
      $display("FAIL drain_count got %0d want %0d", idx, DEPTH + 1);
    end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      in_valid = 1'b1;
      in_insn = $urandom;
      step();
    end
    flush = 1'b1;
    in_valid = 1'b1;
    in_insn = $urandom;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got v=%b r=%b want v=0 r=1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL flush_empty got %0d outputs want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_insn = $urandom;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || act_bus !== '0) begin
      failures++;
      $display("FAIL async_reset got v=%b r=%b bus=%h want 0 1 0",
               out_valid, in_ready, act_bus);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_empty got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    for (int c = 0; c < 500; c++) begin
      op = 6'($urandom_range(0, 63));
      in_valid = 1'($urandom_range(0, 1));
      in_insn = {op, 26'($urandom)};
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
      checks++;
      if (out_valid !== m_ov || in_ready !== (pend.size() < DEPTH)) begin
        failures++;
        $display("FAIL rnd_hs[%0d] got v=%b r=%b want v=%b r=%b",
                 c, out_valid, in_ready, m_ov, pend.size() < DEPTH);
      end
      if (m_ov) begin
        checks++;
        if (act_bus !== exp_bus(m_ow)) begin
          failures++;
          $display("FAIL rnd_bus[%0d] got %h want %h",
                   c, act_bus, exp_bus(m_ow));
        end
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
